// File: rtl/port_alloc_stage_pkg.sv
`default_nettype none
// ============================================================================
// port_alloc_stage_pkg : default router dimensions and a priority-rotation helper
// Revision 1.0
// ============================================================================
package port_alloc_stage_pkg;

    localparam int PA_NUM_PORT     = 5;
    localparam int PA_NUM_CHANNEL  = 5;
    localparam int PA_LOG_NUM_PORT = 3;

    // Input index that sits at priority slot 'off' when 'base' is the head.
    function automatic int rot_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/port_alloc_stage_alloc_pick.sv
`default_nettype none
// ============================================================================
// alloc_pick : one-hot highest-index bit of (candidate & free) plus found flag
// Revision 1.0
// ============================================================================
module alloc_pick #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_cand,
    input  logic [WIDTH-1:0] i_free,
    output logic [WIDTH-1:0] o_pick,
    output logic             o_found
);

    logic [WIDTH-1:0] avail;

    always_comb begin
        avail  = i_cand & i_free;
        o_pick = '0;
        // Ascending scan: the last set bit seen is the highest index.
        for (int i = 0; i < WIDTH; i++) begin
            if (avail[i]) begin
                o_pick    = '0;
                o_pick[i] = 1'b1;
            end
        end
        o_found = |avail;
    end

endmodule
`default_nettype wire

// File: rtl/port_alloc_stage.sv
`default_nettype none
// ============================================================================
// port_alloc_stage : registered rotating-priority output-channel allocator
// Optional ALLOC_DEFLECT_EN adds a second pass granting losers a free channel.
// Revision 1.0
// ============================================================================
module port_alloc_stage
    import port_alloc_stage_pkg::*;
#(
    parameter int NUM_PORT     = PA_NUM_PORT,
    parameter int NUM_CHANNEL  = PA_NUM_CHANNEL,
    parameter int LOG_NUM_PORT = PA_LOG_NUM_PORT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            hold,
    input  logic [NUM_PORT-1:0]             valid_in,
    input  logic [NUM_PORT*NUM_CHANNEL-1:0] req_in,
    output logic [NUM_PORT*NUM_CHANNEL-1:0] alloc_out,
    output logic [NUM_PORT-1:0]             valid_out,
    output logic [NUM_PORT-1:0]             deflect_out,
    output logic [LOG_NUM_PORT-1:0]         rr_ptr
);

    localparam int NC = NUM_CHANNEL;

    logic [NUM_PORT*NC-1:0]    alloc_q, alloc_d;
    logic [NUM_PORT-1:0]       valid_q, valid_d;
    logic [NUM_PORT-1:0]       deflect_q, deflect_d;
    logic [LOG_NUM_PORT-1:0]   rr_ptr_q, rr_ptr_d;

    // Inputs re-ordered so slot 0 is the current highest-priority input.
    logic [NUM_PORT-1:0]       slot_valid;
    logic [NC-1:0]             slot_req   [NUM_PORT];
    logic [NC-1:0]             slot_grant [NUM_PORT];
    logic [NUM_PORT-1:0]       slot_found1;

    always_comb begin : rotate
        slot_valid = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            slot_valid[k] = valid_in[rot_idx(int'(rr_ptr_q), k, NUM_PORT)];
            slot_req[k]   = req_in[rot_idx(int'(rr_ptr_q), k, NUM_PORT)*NC +: NC];
        end
    end

    for (genvar k = 0; k < NUM_PORT; k++) begin : g_slot
        logic [NC-1:0] free_p1;
        logic [NC-1:0] cand_p1;
        logic [NC-1:0] grant_p1;
        logic          found_p1;

        if (k == 0) begin : g_head_p1
            assign free_p1 = '1;
        end else begin : g_link_p1
            assign free_p1 = g_slot[k-1].free_p1 & ~g_slot[k-1].grant_p1;
        end

        assign cand_p1 = slot_valid[k] ? slot_req[k] : '0;

        alloc_pick #(.WIDTH(NC)) u_pick_p1 (
            .i_cand  (cand_p1),
            .i_free  (free_p1),
            .o_pick  (grant_p1),
            .o_found (found_p1)
        );

        assign slot_found1[k] = found_p1;

`ifdef ALLOC_DEFLECT_EN
        logic [NC-1:0] free_p2;
        logic [NC-1:0] cand_p2;
        logic [NC-1:0] grant_p2;
        logic          found_p2;

        // Deflection pass starts from whatever the productive pass left over.
        if (k == 0) begin : g_head_p2
            assign free_p2 = g_slot[NUM_PORT-1].free_p1 & ~g_slot[NUM_PORT-1].grant_p1;
        end else begin : g_link_p2
            assign free_p2 = g_slot[k-1].free_p2 & ~g_slot[k-1].grant_p2;
        end

        assign cand_p2 = {NC{slot_valid[k] & ~found_p1}};

        alloc_pick #(.WIDTH(NC)) u_pick_p2 (
            .i_cand  (cand_p2),
            .i_free  (free_p2),
            .o_pick  (grant_p2),
            .o_found (found_p2)
        );

        assign slot_grant[k] = grant_p1 | grant_p2;
`else
        assign slot_grant[k] = grant_p1;
`endif
    end

    always_comb begin : next_state
        alloc_d   = alloc_q;
        valid_d   = valid_q;
        deflect_d = deflect_q;
        rr_ptr_d  = rr_ptr_q;
        if (!hold) begin
            alloc_d   = '0;
            deflect_d = '0;
            valid_d   = valid_in;
            for (int k = 0; k < NUM_PORT; k++) begin
                alloc_d[rot_idx(int'(rr_ptr_q), k, NUM_PORT)*NC +: NC] = slot_grant[k];
                // A productive-pass loser is either deflected or left unallocated.
                deflect_d[rot_idx(int'(rr_ptr_q), k, NUM_PORT)] = slot_valid[k] & ~slot_found1[k];
            end
            if (|valid_in) begin
                rr_ptr_d = (rr_ptr_q == LOG_NUM_PORT'(NUM_PORT-1)) ? '0 : rr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_q   <= '0;
            valid_q   <= '0;
            deflect_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            alloc_q   <= alloc_d;
            valid_q   <= valid_d;
            deflect_q <= deflect_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign alloc_out   = alloc_q;
    assign valid_out   = valid_q;
    assign deflect_out = deflect_q;
    assign rr_ptr      = rr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_port_alloc_stage.sv
`default_nettype none
// ============================================================================
// tb_port_alloc_stage : directed self-checking bench for port_alloc_stage
// Revision 1.0
// ============================================================================
module tb_port_alloc_stage;

    localparam int NP = 5;
    localparam int NC = 5;
    localparam int LP = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              hold;
    logic [NP-1:0]     valid_in;
    logic [NP*NC-1:0]  req_in;
    logic [NP*NC-1:0]  alloc_out;
    logic [NP-1:0]     valid_out;
    logic [NP-1:0]     deflect_out;
    logic [LP-1:0]     rr_ptr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    port_alloc_stage #(
        .NUM_PORT     (NP),
        .NUM_CHANNEL  (NC),
        .LOG_NUM_PORT (LP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .valid_in    (valid_in),
        .req_in      (req_in),
        .alloc_out   (alloc_out),
        .valid_out   (valid_out),
        .deflect_out (deflect_out),
        .rr_ptr      (rr_ptr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NP-1:0] v, input logic [NP*NC-1:0] r, input logic h);
        valid_in = v;
        req_in   = r;
        hold     = h;
    endtask

    task automatic test_reset();
        drive(5'b11111, 25'h1084210, 1'b0);
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (alloc_out !== 25'h0) $display("FAIL reset_alloc: got %h expected %h", alloc_out, 25'h0);
        else pass_cnt++;
        total_cnt++;
        if (valid_out !== 5'b0) $display("FAIL reset_valid: got %b expected %b", valid_out, 5'b0);
        else pass_cnt++;
        total_cnt++;
        if (deflect_out !== 5'b0) $display("FAIL reset_deflect: got %b expected %b", deflect_out, 5'b0);
        else pass_cnt++;
        total_cnt++;
        if (rr_ptr !== 3'd0) $display("FAIL reset_rr: got %0d expected %0d", rr_ptr, 0);
        else pass_cnt++;
        drive(5'b0, 25'h0, 1'b0);
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        drive(5'b00100, 25'h0001800, 1'b0);
        step();
        total_cnt++;
        if (alloc_out !== 25'h0001000) $display("FAIL single_alloc: got %h expected %h", alloc_out, 25'h0001000);
        else pass_cnt++;
        total_cnt++;
        if (valid_out !== 5'b00100) $display("FAIL single_valid: got %b expected %b", valid_out, 5'b00100);
        else pass_cnt++;
        total_cnt++;
        if (deflect_out !== 5'b0) $display("FAIL single_deflect: got %b expected %b", deflect_out, 5'b0);
        else pass_cnt++;
        total_cnt++;
        if (rr_ptr !== 3'd1) $display("FAIL single_rr: got %0d expected %0d", rr_ptr, 1);
        else pass_cnt++;
    endtask

    task automatic test_contend();
        logic [NP*NC-1:0] exp_alloc;
`ifdef ALLOC_DEFLECT_EN
        exp_alloc = 25'h0000030;
`else
        exp_alloc = 25'h0000020;
`endif
        drive(5'b00011, 25'h0000021, 1'b0);
        step();
        total_cnt++;
        if (alloc_out !== exp_alloc) $display("FAIL contend_alloc: got %h expected %h", alloc_out, exp_alloc);
        else pass_cnt++;
        total_cnt++;
        if (deflect_out !== 5'b00001) $display("FAIL contend_deflect: got %b expected %b", deflect_out, 5'b00001);
        else pass_cnt++;
        total_cnt++;
        if (rr_ptr !== 3'd2) $display("FAIL contend_rr: got %0d expected %0d", rr_ptr, 2);
        else pass_cnt++;
    endtask

    task automatic test_zero_req();
        logic [NP*NC-1:0] exp_alloc;
`ifdef ALLOC_DEFLECT_EN
        exp_alloc = 25'h1000000;
`else
        exp_alloc = 25'h0000000;
`endif
        drive(5'b10000, 25'h0, 1'b0);
        step();
        total_cnt++;
        if (alloc_out !== exp_alloc) $display("FAIL zeroreq_alloc: got %h expected %h", alloc_out, exp_alloc);
        else pass_cnt++;
        total_cnt++;
        if (deflect_out !== 5'b10000) $display("FAIL zeroreq_deflect: got %b expected %b", deflect_out, 5'b10000);
        else pass_cnt++;
        total_cnt++;
        if (rr_ptr !== 3'd3) $display("FAIL zeroreq_rr: got %0d expected %0d", rr_ptr, 3);
        else pass_cnt++;
    endtask

    task automatic test_rotate();
        logic [NP*NC-1:0] exp_alloc;
        logic [NP-1:0]    exp_defl;
        logic [NC-1:0]    top_ch;
        logic [LP-1:0]    exp_rr;
        int               in_idx;
        top_ch = 5'b10000;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        drive(5'b11111, 25'h1084210, 1'b0);
        for (int p = 0; p < NP; p++) begin
            step();
            exp_alloc = '0;
            exp_defl  = 5'b11111;
            exp_defl[p] = 1'b0;
            for (int j = 0; j < NP; j++) begin
                in_idx = (p + j) % NP;
`ifdef ALLOC_DEFLECT_EN
                exp_alloc[in_idx*NC +: NC] = top_ch >> j;
`else
                if (j == 0) exp_alloc[in_idx*NC +: NC] = top_ch;
`endif
            end
            exp_rr = LP'((p + 1) % NP);
            total_cnt++;
            if (alloc_out !== exp_alloc) $display("FAIL rotate_alloc[%0d]: got %h expected %h", p, alloc_out, exp_alloc);
            else pass_cnt++;
            total_cnt++;
            if (deflect_out !== exp_defl) $display("FAIL rotate_deflect[%0d]: got %b expected %b", p, deflect_out, exp_defl);
            else pass_cnt++;
            total_cnt++;
            if (rr_ptr !== exp_rr) $display("FAIL rotate_rr[%0d]: got %0d expected %0d", p, rr_ptr, exp_rr);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        drive(5'b01000, 25'h0010000, 1'b0);
        step();
        total_cnt++;
        if (alloc_out !== 25'h0010000) $display("FAIL hold_pre_alloc: got %h expected %h", alloc_out, 25'h0010000);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            drive(5'b11111 >> c, 25'h1084210 >> c, 1'b1);
            step();
            total_cnt++;
            if (alloc_out !== 25'h0010000) $display("FAIL hold_alloc[%0d]: got %h expected %h", c, alloc_out, 25'h0010000);
            else pass_cnt++;
            total_cnt++;
            if (valid_out !== 5'b01000) $display("FAIL hold_valid[%0d]: got %b expected %b", c, valid_out, 5'b01000);
            else pass_cnt++;
            total_cnt++;
            if (rr_ptr !== 3'd1) $display("FAIL hold_rr[%0d]: got %0d expected %0d", c, rr_ptr, 1);
            else pass_cnt++;
        end
        drive(5'b00100, 25'h0002000, 1'b0);
        step();
        total_cnt++;
        if (alloc_out !== 25'h0002000) $display("FAIL release_alloc: got %h expected %h", alloc_out, 25'h0002000);
        else pass_cnt++;
        total_cnt++;
        if (deflect_out !== 5'b0) $display("FAIL release_deflect: got %b expected %b", deflect_out, 5'b0);
        else pass_cnt++;
        total_cnt++;
        if (rr_ptr !== 3'd2) $display("FAIL release_rr: got %0d expected %0d", rr_ptr, 2);
        else pass_cnt++;
    endtask

    task automatic test_idle();
        drive(5'b0, 25'h1FFFFFF, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            total_cnt++;
            if (alloc_out !== 25'h0) $display("FAIL idle_alloc[%0d]: got %h expected %h", c, alloc_out, 25'h0);
            else pass_cnt++;
            total_cnt++;
            if (valid_out !== 5'b0) $display("FAIL idle_valid[%0d]: got %b expected %b", c, valid_out, 5'b0);
            else pass_cnt++;
            total_cnt++;
            if (rr_ptr !== 3'd2) $display("FAIL idle_rr[%0d]: got %0d expected %0d", c, rr_ptr, 2);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(5'b0, 25'h0, 1'b0);
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_single();
        test_contend();
        test_zero_req();
        test_rotate();
        test_hold();
        test_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/port_alloc_stage.md
# port_alloc_stage

Registered output-port allocation stage for the bufferless router pipeline. It sits directly upstream of the alloc-to-outSel translation stage. Each cycle it takes the productive-direction request vectors of up to NUM_PORT incoming flits and resolves them against a rotating input priority. It registers one one-hot channel allocation per input. With the deflection option compiled in, losing flits are deflected to a free channel.

## Interface
Parameters:
- NUM_PORT, 5, number of router input ports / flit slots (from global.vh)
- NUM_CHANNEL, 5, number of output channels; width of every req/alloc vector (from global.vh)
- LOG_NUM_PORT, 3, width of the round-robin pointer (from global.vh)

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high
- hold  input  1  pipeline stall; when high, all registers keep their value
- valid_in  input  NUM_PORT  flit present on input i
- req_in  input  NUM_PORT*NUM_CHANNEL  productive-channel request of input i in slice [i*NUM_CHANNEL +: NUM_CHANNEL]; any number of bits may be set
- alloc_out  output  NUM_PORT*NUM_CHANNEL  registered one-hot (or zero) allocation per input, same slicing
- valid_out  output  NUM_PORT  registered copy of valid_in
- deflect_out  output  NUM_PORT  registered; input i was granted a non-requested channel
- rr_ptr  output  LOG_NUM_PORT  current highest-priority input index

## Operation
- Priority order: inputs rr_ptr, rr_ptr+1, …, wrapping modulo NUM_PORT.
- Pass 1 (productive): in priority order, each valid input takes the highest-index channel that is both requested and still free. Channel then marked taken.
- Pass 2 (deflect, macro-dependent): in the same priority order, each valid input without a grant takes the highest-index free channel.
- Invalid inputs never receive a grant; their alloc slice is zero.
- Valid input with all-zero req_in: loses pass 1 and is handled by pass 2.
- No channel is granted to two inputs (alloc columns are at most one-hot).
- rr_ptr advances by 1 on every non-hold cycle with |valid_in. It wraps NUM_PORT-1 → 0. It holds when no input is valid.
- Reset: alloc_out=0, valid_out=0, deflect_out=0, rr_ptr=0. This is immediate (asynchronous) and discards any in-flight allocation.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- hold high at edge N: outputs and rr_ptr unchanged. Inputs during that cycle are ignored; the upstream stage re-presents them.
- Allocation is purely combinational from valid_in, req_in and rr_ptr. There is no multi-cycle state besides rr_ptr.
- Reset deasserted mid-stream: first sampling edge uses rr_ptr=0.

## Configuration
- ALLOC_DEFLECT_EN defined: pass 2 is active. Because valid inputs never exceed NUM_PORT ≤ NUM_CHANNEL, every valid input receives exactly one channel. deflect_out[i] is set when input i is granted a channel outside req_in[i].
- ALLOC_DEFLECT_EN undefined: pass 2 is removed. Losers get alloc slice 0, which downstream translates to the all-ones "no port" select. deflect_out[i] instead flags "valid but unallocated".

## Structure
- NUM_PORT, NUM_CHANNEL and LOG_NUM_PORT stay in the shared global.vh header. No new typedefs are needed.
- One sub-module, alloc_pick. It takes a candidate vector and a free vector, and returns the one-hot highest-index set bit of (candidate & free) plus a found flag. It is instantiated per input per pass in the priority chain.
- The top level holds the rotation, the grant chain, the output registers and rr_ptr.

## Test plan
- Reset pulse mid-traffic → alloc_out=0, valid_out=0, deflect_out=0, rr_ptr=0 immediately, before any clock edge.
- Single valid input 2, req=5'b00110, rr_ptr=0 → next cycle alloc slice 2 = 5'b00100, deflect_out=0, rr_ptr=1.
- Inputs 0 and 1 both req 5'b00001, rr_ptr=1 → input 1 gets 00001. Input 0 gets 10000 with deflect_out[0]=1 (ALLOC_DEFLECT_EN), or 00000 with deflect_out[0]=1 (without).
- All 5 inputs valid, each req 5'b10000, 5 consecutive cycles → each cycle exactly one input holds 10000 (rr_ptr owner, rotating 0..4 then wrap to 0). With deflection, all five columns are used with no duplicate grant.
- hold high for 3 cycles with changing inputs → outputs and rr_ptr frozen. After release, the first new allocation reflects inputs at the release edge.
- valid_in=0 for several cycles → alloc_out=0, rr_ptr unchanged.
